// File: rtl/risc_pkg.sv
// Shared RiSC-16 definitions: opcodes, instruction field positions, halt encoding
// and the fetch-unit state type.
package risc_pkg;

  localparam logic [2:0] ADD    = 3'b000;
  localparam logic [2:0] ADDI   = 3'b001;
  localparam logic [2:0] NAND   = 3'b010;
  localparam logic [2:0] LUI    = 3'b011;
  localparam logic [2:0] SW     = 3'b100;
  localparam logic [2:0] LW     = 3'b101;
  localparam logic [2:0] BEQ    = 3'b110;
  localparam logic [2:0] JALR   = 3'b111;
  // Extended ops (halt, etc.) reuse the JALR opcode with a nonzero imm7.
  localparam logic [2:0] EXTEND = 3'b111;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 13;
  localparam int RA_MSB    = 12;
  localparam int RA_LSB    = 10;
  localparam int RB_MSB    = 9;
  localparam int RB_LSB    = 7;
  localparam int RC_MSB    = 2;
  localparam int RC_LSB    = 0;
  localparam int IMM7_MSB  = 6;
  localparam int IMM7_LSB  = 0;
  localparam int IMM10_MSB = 9;
  localparam int IMM10_LSB = 0;

  localparam logic [15:0] HALT_INSTR = 16'hE071;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr == HALT_INSTR;
  endfunction

endpackage

// File: rtl/risc_fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs. Flush beats push; the head is driven
// straight from the storage flops, so it never sees the memory response path.
module risc_fetch_queue
  import risc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [15:0]              push_pc,
  input  logic [15:0]              push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [15:0]              head_pc,
  output logic [15:0]              head_instr
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_pc, push_instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Zero when empty so the decode outputs read 0 out of reset.
  assign {head_pc, head_instr} = empty ? 32'h0 : mem[rd_ptr];

endmodule

// File: rtl/risc_fetch_unit.sv
// RiSC-16 instruction fetch front end with credit-limited prefetch queue.
// Optional RISC_FETCH_STATS_EN adds saturating fetched/dropped counters.
module risc_fetch_unit
  import risc_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
`ifdef RISC_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped
`endif
);

  localparam int            CW  = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [15:0]   fetch_pc;
  logic [15:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW:0]   inflight;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          q_empty;

  // Queued plus in-flight never exceeds DEPTH, so a push can always land.
  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst_n && (state == FETCH) && !redirect_valid && (inflight < CAP);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = (discard != '0) || (state == HALTED) || redirect_valid;
  assign push           = imem_rsp_valid && !rsp_drop;
  assign dec_valid      = !q_empty;
  assign pop            = dec_valid && dec_ready;
  assign halted         = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)                     state_nxt = FETCH;
    else if (push && is_halt(imem_rsp_data)) state_nxt = HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        // Everything still in flight after this cycle belongs to the old stream.
        discard  <= outstanding - (imem_rsp_valid ? CW'(1) : CW'(0));
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 16'd1;
        if (push)     rsp_pc   <= rsp_pc + 16'd1;
        if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  risc_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (rsp_pc),
    .push_instr (imem_rsp_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .empty      (q_empty),
    .head_pc    (dec_pc),
    .head_instr (dec_instr)
  );

`ifdef RISC_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      if (push && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
      if (imem_rsp_valid && !push && (stat_dropped != '1)) stat_dropped <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule
